// File: rtl/frame_arbiter_if.sv
// Bus bundle for frame_arbiter: two row-write requesters, swap control and
// the scanner-facing frame/row outputs.
interface frame_arbiter_if;
  // req_x is held with row_x/data_x stable until gnt_x; the row write takes
  // effect on the rising edge where req_x and gnt_x are both high, and gnt_x
  // is a combinational function of req_a, req_b and the priority register.
  logic         req_a;
  logic [2:0]   row_a;
  logic [15:0]  data_a;
  logic         gnt_a;
  logic         req_b;
  logic [2:0]   row_b;
  logic [15:0]  data_b;
  logic         gnt_b;
  logic         swap_req;
  logic         swap_done;
  logic [127:0] frame;
  logic         row_tick;
  logic [2:0]   row_idx;

  modport master (
    output req_a, row_a, data_a, req_b, row_b, data_b, swap_req,
    input  gnt_a, gnt_b, swap_done, frame, row_tick, row_idx
  );

  modport slave (
    input  req_a, row_a, data_a, req_b, row_b, data_b, swap_req,
    output gnt_a, gnt_b, swap_done, frame, row_tick, row_idx
  );
endinterface

// File: rtl/frame_arbiter.sv
// Double-buffered 8x16 frame store: round-robin row writes into the back
// buffer, tear-free front/back exchange at frame boundaries, row scan timing.
module frame_arbiter #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input logic           clk,
  input logic           rst,
  frame_arbiter_if.slave bus
);

  localparam logic [15:0] LAST_CNT = 16'(SCAN_DIV - 1);

  logic [127:0] buf0;
  logic [127:0] buf1;
  logic         sel;
  logic         prio_b;
  logic         pending;
  logic         swap_done_q;
  logic [15:0]  scan_cnt;
  logic [2:0]   row_idx_q;

  logic         gnt_a;
  logic         gnt_b;
  logic         wr_en;
  logic [2:0]   wr_row;
  logic [15:0]  wr_data;
  logic [6:0]   wr_lsb;
  logic         row_tick;
  logic         frame_end;
  logic         swap_now;

  always_comb begin
    gnt_a     = 1'b0;
    gnt_b     = 1'b0;
    wr_en     = 1'b0;
    wr_row    = bus.row_a;
    wr_data   = bus.data_a;
    wr_lsb    = '0;
    row_tick  = 1'b0;
    frame_end = 1'b0;
    swap_now  = 1'b0;

    // Grants are forced low during reset so no write can race the clear.
    if (!rst) begin
      gnt_a = bus.req_a && (!bus.req_b || !prio_b);
      gnt_b = bus.req_b && (!bus.req_a ||  prio_b);
    end
    wr_en = gnt_a || gnt_b;
    if (gnt_b) begin
      wr_row  = bus.row_b;
      wr_data = bus.data_b;
    end
    // Row 0 sits in the top 16 bits of the frame.
    wr_lsb = {3'd7 - wr_row, 4'd0};

    row_tick  = (scan_cnt == LAST_CNT);
    frame_end = row_tick && (row_idx_q == 3'd7);
    swap_now  = frame_end && (pending || bus.swap_req);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf0        <= '0;
      buf1        <= '0;
      sel         <= 1'b0;
      prio_b      <= 1'b0;
      pending     <= 1'b0;
      swap_done_q <= 1'b0;
      scan_cnt    <= '0;
      row_idx_q   <= '0;
    end else begin
      // The write uses the pre-toggle sel, so a write on the swap edge lands
      // in the buffer that becomes the new front.
      if (wr_en) begin
        if (sel) buf0[wr_lsb +: 16] <= wr_data;
        else     buf1[wr_lsb +: 16] <= wr_data;
      end

      if (gnt_a)      prio_b <= 1'b1;
      else if (gnt_b) prio_b <= 1'b0;

      scan_cnt <= row_tick ? 16'd0 : scan_cnt + 16'd1;
      if (row_tick) row_idx_q <= row_idx_q + 3'd1;

      if (swap_now) begin
        sel     <= ~sel;
        pending <= 1'b0;
      end else if (bus.swap_req) begin
        pending <= 1'b1;
      end
      swap_done_q <= swap_now;
    end
  end

  assign bus.gnt_a     = gnt_a;
  assign bus.gnt_b     = gnt_b;
  assign bus.frame     = sel ? buf1 : buf0;
  assign bus.row_tick  = row_tick;
  assign bus.row_idx   = row_idx_q;
  assign bus.swap_done = swap_done_q;

endmodule

// File: tb/tb_frame_arbiter.sv
// Directed bench for frame_arbiter with SCAN_DIV=4 (4 cycles/row, 32/frame):
// arbitration vector table plus hand-written swap and reset sequences.
module tb_frame_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  frame_arbiter_if bus();

  frame_arbiter #(.SCAN_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        ra;
    logic [2:0]  rwa;
    logic [15:0] da;
    logic        rb;
    logic [2:0]  rwb;
    logic [15:0] db;
    logic        ga;
    logic        gb;
  } vec_t;

  vec_t         vecs[12];
  logic [127:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;

  localparam logic [127:0] TABLE_FRAME = 128'h1111_2222_3333_0000_4444_5555_6666_7777;
  localparam logic [127:0] A5_FRAME    = 128'h0000_0000_0000_A5A5_0000_0000_0000_0000;
  localparam logic [127:0] FF_FRAME    = 128'hFFFF_0000_0000_A5A5_0000_0000_0000_0000;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus.req_a    = 1'b0;
    bus.row_a    = 3'd0;
    bus.data_a   = 16'h0;
    bus.req_b    = 1'b0;
    bus.row_b    = 3'd0;
    bus.data_b   = 16'h0;
    bus.swap_req = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; checks run at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  // Caller is already in scan cycle 0 (counter 0, row 0).
  task automatic idle_check(input int n, input logic [127:0] exp_frame);
    for (int k = 0; k < n; k++) begin
      if (k > 0) next_cycle();
      @(negedge clk);
      check("idle_tick", bus.row_tick, (k % 4) == 3);
      check("idle_row", bus.row_idx, (k / 4) % 8);
      check("idle_frame", bus.frame, exp_frame);
      check("idle_swap_done", bus.swap_done, 1'b0);
    end
  endtask

  task automatic pulse_at_row(input logic [2:0] r);
    int n;
    n = 0;
    do begin
      next_cycle();
      n++;
    end while (bus.row_idx != r && n < 40);
    check("reach_row", bus.row_idx, r);
    bus.swap_req = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_swap(input logic [127:0] old_frame);
    bit           seen;
    logic [127:0] exp_f;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      next_cycle();
      @(negedge clk);
      if (bus.swap_done) seen = 1'b1;
      else check("frame_hold", bus.frame, old_frame);
    end
    check("swap_seen", seen, 1'b1);
    exp_f = exp_q.pop_front();
    check("swap_frame", bus.frame, exp_f);
    check("swap_row_idx", bus.row_idx, 3'd0);
    next_cycle();
    @(negedge clk);
    check("swap_done_width", bus.swap_done, 1'b0);
    check("frame_after_swap", bus.frame, exp_f);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 3'd0, 16'h1111, 1'b1, 3'd1, 16'h2222, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 3'd0, 16'h1111, 1'b1, 3'd1, 16'h2222, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 3'd0, 16'h1111, 1'b1, 3'd1, 16'h2222, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 3'd0, 16'h1111, 1'b1, 3'd1, 16'h2222, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 3'd2, 16'h3333, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 3'd2, 16'h3333, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 16'h4444, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 16'h5555, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 3'd6, 16'h6666, 1'b1, 3'd7, 16'h7777, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 3'd6, 16'hDEAD, 1'b1, 3'd7, 16'h7777, 1'b0, 1'b1};

    // Reset state, with both requests forced high.
    clear_inputs();
    rst = 1'b1;
    bus.req_a = 1'b1;
    bus.req_b = 1'b1;
    #3;
    check("rst_gnt_a", bus.gnt_a, 1'b0);
    check("rst_gnt_b", bus.gnt_b, 1'b0);
    check("rst_frame", bus.frame, 128'h0);
    check("rst_row_tick", bus.row_tick, 1'b0);
    check("rst_row_idx", bus.row_idx, 3'd0);
    check("rst_swap_done", bus.swap_done, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_inputs();

    // Idle scan over one full frame plus a wrap.
    idle_check(34, 128'h0);

    // Arbitration table; every write goes to the hidden back buffer.
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      bus.req_a  = vecs[i].ra;
      bus.row_a  = vecs[i].rwa;
      bus.data_a = vecs[i].da;
      bus.req_b  = vecs[i].rb;
      bus.row_b  = vecs[i].rwb;
      bus.data_b = vecs[i].db;
      @(negedge clk);
      check($sformatf("vec%0d_gnt_a", i), bus.gnt_a, vecs[i].ga);
      check($sformatf("vec%0d_gnt_b", i), bus.gnt_b, vecs[i].gb);
      check($sformatf("vec%0d_frame", i), bus.frame, 128'h0);
    end

    // Swap exposes the table contents.
    next_cycle();
    bus.swap_req = 1'b1;
    @(negedge clk);
    exp_q.push_back(TABLE_FRAME);
    wait_swap(128'h0);

    // Row 3 = A5A5 with swap requested at row 2.
    next_cycle();
    bus.req_a  = 1'b1;
    bus.row_a  = 3'd3;
    bus.data_a = 16'hA5A5;
    @(negedge clk);
    check("row3_gnt_a", bus.gnt_a, 1'b1);
    pulse_at_row(3'd2);
    exp_q.push_back(A5_FRAME);
    wait_swap(TABLE_FRAME);

    // Three swap requests in one frame give exactly one exchange.
    pulse_at_row(3'd1);
    pulse_at_row(3'd3);
    pulse_at_row(3'd5);
    exp_q.push_back(TABLE_FRAME);
    wait_swap(A5_FRAME);
    for (int n = 0; n < 40; n++) begin
      next_cycle();
      @(negedge clk);
      check("single_swap_done", bus.swap_done, 1'b0);
      check("single_swap_frame", bus.frame, TABLE_FRAME);
    end

    // Write granted on the swap edge itself, swap requested in the boundary cycle.
    begin
      int n;
      n = 0;
      do begin
        next_cycle();
        n++;
      end while (!(bus.row_idx == 3'd7 && bus.row_tick) && n < 40);
    end
    check("reach_boundary", {bus.row_tick, bus.row_idx}, 4'hF);
    bus.swap_req = 1'b1;
    bus.req_b    = 1'b1;
    bus.row_b    = 3'd0;
    bus.data_b   = 16'hFFFF;
    @(negedge clk);
    check("edge_gnt_b", bus.gnt_b, 1'b1);
    check("edge_gnt_a", bus.gnt_a, 1'b0);
    check("edge_frame_before", bus.frame, TABLE_FRAME);
    next_cycle();
    @(negedge clk);
    check("edge_swap_done", bus.swap_done, 1'b1);
    check("edge_frame_after", bus.frame, FF_FRAME);

    // Asynchronous reset with a swap pending at row 5.
    pulse_at_row(3'd5);
    next_cycle();
    #2;
    rst = 1'b1;
    #1;
    check("arst_frame", bus.frame, 128'h0);
    check("arst_row_idx", bus.row_idx, 3'd0);
    check("arst_row_tick", bus.row_tick, 1'b0);
    check("arst_swap_done", bus.swap_done, 1'b0);
    bus.req_a = 1'b1;
    bus.req_b = 1'b1;
    #1;
    check("arst_gnt_a", bus.gnt_a, 1'b0);
    check("arst_gnt_b", bus.gnt_b, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_inputs();
    idle_check(40, 128'h0);

    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
